// File: rtl/ndma_obi_sub_mem.sv
// OBI subordinate scratchpad: word-addressed flop array answering reads/writes in order.
// Latency: response (rvalid_o) exactly Latency cycles after the accepting clock edge.
// Backpressure: gnt_o withheld when MaxOutstanding responses are in flight (and, with
//   NDMA_SUB_STALL_EN defined, on pseudo-random LFSR wait states).
module ndma_obi_sub_mem #(
  parameter int Depth          = 256,
  parameter int DataWidth      = 32,
  parameter int Latency        = 1,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [31:0]            addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o
);

  localparam int AW = $clog2(Depth);
  localparam int BW = DataWidth / 8;
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [31:0] AddrLimit = 32'(Depth * 4);

  typedef struct packed {
    logic                 vld;
    logic [DataWidth-1:0] dat;
    logic                 err;
  } rsp_t;

  logic [DataWidth-1:0] mem [Depth];
  rsp_t                 pipe [Latency];
  logic [CW-1:0]        cnt;
  logic                 stall;
  logic                 acc;
  logic                 bad;
  logic [AW-1:0]        idx;
  logic [DataWidth-1:0] rd;

`ifdef NDMA_SUB_STALL_EN
  logic [7:0] lfsr;

  // Galois LFSR free-runs every cycle; its low bit inserts wait states
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= 8'hA5;
    else       lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // A slot frees up in the same cycle the oldest response leaves, so grant then too
  assign gnt_o = req_i & ~rst_i & ~stall & ((cnt < CW'(MaxOutstanding)) | rvalid_o);
  assign acc   = gnt_o;

  assign idx = addr_i[AW+1:2];
  assign bad = (addr_i[1:0] != 2'b00) | (addr_i >= AddrLimit);
  assign rd  = (!we_i && !bad) ? mem[idx] : '0;

  // Array: cleared on reset, byte-masked write committed on the accept edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (acc && we_i && !bad) begin
      for (int b = 0; b < BW; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Response shift pipeline; empty stages carry zeros so outputs idle at 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= acc ? '{vld: 1'b1, dat: rd, err: bad} : '0;
      for (int i = 1; i < Latency; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rvalid_o = pipe[Latency-1].vld;
  assign rdata_o  = pipe[Latency-1].dat;
  assign err_o    = pipe[Latency-1].err;

  // Outstanding count: accept adds one, response removes one
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 cnt <= '0;
    else if (acc && !rvalid_o) cnt <= cnt + CW'(1);
    else if (!acc && rvalid_o) cnt <= cnt - CW'(1);
  end

endmodule

// File: tb/tb_ndma_obi_sub_mem.sv
module tb_ndma_obi_sub_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req1 = 1'b0, req3 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        gnt1, gnt3, rvalid1, rvalid3, err1, err3;
  logic [31:0] rdata1, rdata3;

  int checks = 0;
  int failures = 0;
  int stall_seen = 0;

  always #5 clk = ~clk;

  ndma_obi_sub_mem #(.Depth(256), .DataWidth(32), .Latency(1), .MaxOutstanding(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1));

  ndma_obi_sub_mem #(.Depth(256), .DataWidth(32), .Latency(3), .MaxOutstanding(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3));

  // Count cycles where the Latency-1 instance refuses a pending request
  always @(posedge clk) if (!rst && req1 && !gnt1) stall_seen++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One request on the selected instance, held until granted, then response checked
  task automatic txn(input bit sel, input logic we_v, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [31:0] er, input logic ee, input string nm);
    int  lat;
    bit  got;
    lat = sel ? 3 : 1;
    got = 0;
    @(negedge clk);
    we = we_v; addr = a; be = b; wdata = d;
    if (sel) req3 = 1'b1; else req1 = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      #1;
      if (sel ? gnt3 : gnt1) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      check({nm, "_grant"}, 32'd0, 32'd1);
      req1 = 1'b0; req3 = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin req1 = 1'b0; req3 = 1'b0; end
      #1;
      if (k < lat) begin
        check({nm, "_early_rvalid"}, {31'd0, sel ? rvalid3 : rvalid1}, 32'd0);
      end else begin
        check({nm, "_rvalid"}, {31'd0, sel ? rvalid3 : rvalid1}, 32'd1);
        check({nm, "_rdata"}, sel ? rdata3 : rdata1, er);
        check({nm, "_err"}, {31'd0, sel ? err3 : err1}, {31'd0, ee});
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [15];

  initial begin
    int          n_acc, n_rsp, max_fl, cyc;
    bit          g;
    logic [31:0] pat;

    vt[0]  = '{1'b1, 32'h010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h020, 4'hF, 32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h020, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h020, 4'h0, 32'h0,        32'h11BB33DD, 1'b0};
    vt[5]  = '{1'b1, 32'h000, 4'hF, 32'h5A5A1234, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h003, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[7]  = '{1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[8]  = '{1'b1, 32'h001, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[9]  = '{1'b0, 32'h000, 4'h0, 32'h0,        32'h5A5A1234, 1'b0};
    vt[10] = '{1'b1, 32'h3FC, 4'h0, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[11] = '{1'b0, 32'h3FC, 4'h0, 32'h0,        32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h400, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b1, 32'h3FC, 4'h8, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[14] = '{1'b0, 32'h3FC, 4'h0, 32'h0,        32'hCA000000, 1'b0};

    // Reset state, with a request pending to prove gnt is suppressed
    req1 = 1'b1;
    #12;
    check("rst_gnt",    {31'd0, gnt1},    32'd0);
    check("rst_rvalid", {31'd0, rvalid1}, 32'd0);
    check("rst_rdata",  rdata1,           32'd0);
    check("rst_err",    {31'd0, err1},    32'd0);
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the Latency=1 instance
    for (int i = 0; i < 15; i++)
      txn(1'b0, vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err,
          $sformatf("vec%0d", i));

    // Latency=3 / MaxOutstanding=2: preload, then 10 back-to-back reads
    for (int i = 0; i < 10; i++)
      txn(1'b1, 1'b1, 32'(i * 4), 4'hF, 32'h1000 + 32'(i), 32'h0, 1'b0, "pre3");
    n_acc = 0; n_rsp = 0; max_fl = 0; cyc = 0;
    we = 1'b0; be = 4'h0;
    while (n_rsp < 10 && cyc < 80) begin
      @(negedge clk);
      if (n_acc == 10) req3 = 1'b0;
      else begin req3 = 1'b1; addr = 32'(n_acc * 4); end
      #1;
      g = gnt3 && req3;
`ifndef NDMA_SUB_STALL_EN
      if (cyc < 9) check($sformatf("gnt_pat%0d", cyc), {31'd0, g}, {31'd0, (cyc % 3) != 2});
`endif
      if (n_acc - n_rsp > max_fl) max_fl = n_acc - n_rsp;
      if (rvalid3) begin
        check("b2b_rdata", rdata3, 32'h1000 + 32'(n_rsp));
        n_rsp++;
      end
      @(posedge clk);
      if (g) n_acc++;
      cyc++;
    end
    req3 = 1'b0;
    check("b2b_responses", 32'(n_rsp), 32'd10);
    check("b2b_max_outstanding_le2", {31'd0, max_fl <= 2}, 32'd1);

    // Reset with two reads in flight: nothing may emerge afterwards
    n_acc = 0; cyc = 0;
    we = 1'b0; addr = 32'h0;
    while (n_acc < 2 && cyc < 100) begin
      @(negedge clk);
      req3 = 1'b1;
      addr = 32'(n_acc * 4);
      #1;
      g = gnt3;
      @(posedge clk);
      if (g) n_acc++;
      cyc++;
    end
    check("rst_inflight_accepts", 32'(n_acc), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_gnt",    {31'd0, gnt3},    32'd0);
    check("rst_mid_rvalid", {31'd0, rvalid3}, 32'd0);
    req3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_rsp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (rvalid3 || rvalid1 || err3 || rdata3 != 0) n_rsp++;
    end
    check("rst_no_stale_rsp", 32'(n_rsp), 32'd0);
    txn(1'b1, 1'b0, 32'h000, 4'h0, 32'h0, 32'h0, 1'b0, "rst_mem3_w0");
    txn(1'b1, 1'b0, 32'h004, 4'h0, 32'h0, 32'h0, 1'b0, "rst_mem3_w1");
    txn(1'b0, 1'b0, 32'h010, 4'h0, 32'h0, 32'h0, 1'b0, "rst_mem1_w4");

    // DMA-style copy: fill instance 1, read each word back and write it to instance 3
    stall_seen = 0;
    for (int i = 0; i < 256; i++) begin
      pat = 32'hA5000000 | (32'(i) << 8) | (32'(255 - i));
      txn(1'b0, 1'b1, 32'(i * 4), 4'hF, pat, 32'h0, 1'b0, "cpy_fill");
    end
    for (int i = 0; i < 256; i++) begin
      pat = 32'hA5000000 | (32'(i) << 8) | (32'(255 - i));
      txn(1'b0, 1'b0, 32'(i * 4), 4'h0, 32'h0, pat, 1'b0, "cpy_src_rd");
      txn(1'b1, 1'b1, 32'(i * 4), 4'hF, pat, 32'h0, 1'b0, "cpy_dst_wr");
    end
    for (int i = 0; i < 256; i++) begin
      pat = 32'hA5000000 | (32'(i) << 8) | (32'(255 - i));
      txn(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, pat, 1'b0, "cpy_dst_rd");
    end
`ifdef NDMA_SUB_STALL_EN
    check("stall_wait_states_seen", {31'd0, stall_seen > 0}, 32'd1);
`else
    check("no_wait_states", 32'(stall_seen), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
